epcs_flash_responder: RTL and testbench
=======================================

// Module: epcs_flash_responder
// PURPOSE
//  Slave end of the EPCS serial-flash interface: emulates an EPCS device so the Nios EPCS
//  controller (dclk/sce/sdo out, data0 in) can boot and run from on-chip RAM in sim and bring-up.
//  Oversamples the serial lines in the system clock domain, decodes opcodes, serves reads and
//  page programs from an external 8-bit memory port, and reports status (WIP/WEL).
// PARAMETERS
//  MEM_AW         16     backing-memory address width; flash address bits above MEM_AW-1 ignored
//  SILICON_ID     8'h14  byte returned by READ ID (0xAB)
//  PROG_BUSY_CYC  64     clk_clk cycles WIP stays 1 after a completed page program
// PORTS
//  clk_clk        in   1       system clock; must be >= 4x epcs_dclk
//  reset_reset_n  in   1       asynchronous active-low reset
//  epcs_dclk      in   1       serial clock from master (async, synchronised internally)
//  epcs_sce       in   1       chip select, active low (async)
//  epcs_sdo       in   1       master-out serial data, MSB first
//  epcs_data0     out  1       slave-out serial data, MSB first
//  mem_addr       out  MEM_AW  backing-memory byte address
//  mem_rd         out  1       read strobe; mem_rdata valid on the following cycle
//  mem_rdata      in   8       read data
//  mem_we         out  1       single-cycle write strobe
//  mem_wdata      out  8       write data
//  busy           out  1       mirror of status WIP
// BEHAVIOUR
//  - Reset: epcs_data0=1, mem_rd=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, WEL=0, state IDLE.
//  - Inputs pass 2-FF sync; dclk rise/fall detected on synced copy. SPI mode 0/3: sample sdo on
//    dclk rise, update data0 on dclk fall. Bit counter 0..7, byte complete on 8th rise.
//  - States: IDLE -> CMD (sce falls) -> {ADDR(3 bytes, MSB first) | DUMMY(3 bytes) | STATUS | IGNORE}
//    -> DATA_RD / DATA_WR / ID. sce high in any state: immediately IDLE, bit counter cleared,
//    partial byte discarded, data0=1, no mem strobe issued.
//  - Opcodes: 0x03 READ, 0x05 READ STATUS, 0x06 WREN (sets WEL at sce rise), 0x04 WRDI (clears WEL),
//    0x02 PAGE PROGRAM, 0xAB READ ID. Unknown opcode -> IGNORE until sce high, data0=1.
//  - While WIP=1 every opcode except 0x05 goes to IGNORE.
//  - Status byte = {6'b0, WEL, WIP}; repeated every byte while sce low.
//  - READ: after last addr bit, mem_rd pulses once; loaded byte shifts out from next dclk fall.
//    Next mem_rd issued on bit 0 of each byte; address increments, wraps at 2^MEM_AW.
//  - PAGE PROGRAM: ignored if WEL=0. Each complete data byte -> one mem_we pulse within 2 clk of
//    the 8th rise; address low 8 bits wrap within the 256-byte page, upper bits fixed.
//    On sce rise with >=1 byte written: WEL=0, WIP=1 for PROG_BUSY_CYC cycles. Zero bytes: no WIP.
//  - READ ID: after 3 dummy bytes, SILICON_ID repeated each byte.
//  - mem_rd and mem_we never asserted in the same cycle.
// CONFIGURATION
//  EPCS_RESP_ERASE_EN defined: 0xD8 SECTOR ERASE (3 addr bytes, 64 KB sector, clipped to memory)
//   and 0xC7 BULK ERASE accepted when WEL=1; on sce rise a sweep writes 8'hFF one byte per clk
//   over the range, WIP=1 throughout, WEL=0 at start, WIP=0 the cycle after the last write.
//  Not defined: 0xD8/0xC7 treated as unknown opcodes (IGNORE); no sweep logic built.
// STRUCTURE
//  Package epcs_resp_pkg: opcode localparams, state enum, status bit indices (WIP=0, WEL=1).
//  Sub-module epcs_resp_sync: 2-FF synchronisers plus rise/fall pulse generation for dclk/sce/sdo.
// TESTING
//  1. WREN, PP addr 0x000010 bytes A5,5A; READ 0x000010 x2 -> mem_we twice, data0 returns A5,5A.
//  2. READ STATUS right after PP -> 0x01 repeated; poll until PROG_BUSY_CYC elapsed -> 0x00.
//  3. PP without WREN at 0x20 -> no mem_we; READ 0x20 returns prior content unchanged.
//  4. PP start 0x0000FE, 4 bytes -> writes at 0xFE,0xFF,0x00,0x01 (page wrap).
//  5. READ ID (0xAB + 3 dummy) -> 0x14; sce raised after 5 bits of READ opcode -> IDLE, no mem_rd.
//  6. EPCS_RESP_ERASE_EN: WREN, BULK ERASE -> 2^MEM_AW writes of 0xFF, busy high throughout;
//     without macro -> 0xC7 ignored, zero mem_we.

Source files
------------

// File: rtl/epcs_resp_pkg.sv
// rtl/epcs_resp_pkg.sv - opcodes, states and status layout for the EPCS responder
package epcs_resp_pkg;

  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_RDID = 8'hAB;
  localparam logic [7:0] OP_SE   = 8'hD8;
  localparam logic [7:0] OP_BE   = 8'hC7;

  localparam int STAT_WIP    = 0;
  localparam int STAT_WEL    = 1;
  localparam int SECTOR_BITS = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_STATUS,
    ST_IGNORE,
    ST_DATA_RD,
    ST_DATA_WR,
    ST_ID
  } state_e;

endpackage

// File: rtl/epcs_resp_sync.sv
// rtl/epcs_resp_sync.sv - 2-FF synchronisers and edge pulses for the EPCS serial lines
module epcs_resp_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic dclk_i,
  input  logic sce_i,
  input  logic sdo_i,
  output logic dclk_rise,
  output logic dclk_fall,
  output logic sce_lvl,
  output logic sce_rise,
  output logic sce_fall,
  output logic sdo_lvl
);

  logic [2:0] dclk_q, dclk_d;
  logic [2:0] sce_q, sce_d;
  logic [1:0] sdo_q, sdo_d;

  always_comb begin
    dclk_d = {dclk_q[1:0], dclk_i};
    sce_d  = {sce_q[1:0], sce_i};
    sdo_d  = {sdo_q[0], sdo_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dclk_q <= 3'b000;
      sce_q  <= 3'b111;
      sdo_q  <= 2'b00;
    end else begin
      dclk_q <= dclk_d;
      sce_q  <= sce_d;
      sdo_q  <= sdo_d;
    end
  end

  // sdo shares the dclk sync depth, so sdo_lvl is aligned with dclk_rise
  assign dclk_rise = dclk_q[1] & ~dclk_q[2];
  assign dclk_fall = ~dclk_q[1] & dclk_q[2];
  assign sce_lvl   = sce_q[1];
  assign sce_rise  = sce_q[1] & ~sce_q[2];
  assign sce_fall  = ~sce_q[1] & sce_q[2];
  assign sdo_lvl   = sdo_q[1];

endmodule

// File: rtl/epcs_flash_responder.sv
// rtl/epcs_flash_responder.sv - EPCS serial-flash slave emulation over an 8-bit memory port
// Optional sector/bulk erase sweep built when EPCS_RESP_ERASE_EN is defined.
module epcs_flash_responder
  import epcs_resp_pkg::*;
#(
  parameter int          MEM_AW        = 16,
  parameter logic [7:0]  SILICON_ID    = 8'h14,
  parameter int          PROG_BUSY_CYC = 64
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              epcs_dclk,
  input  logic              epcs_sce,
  input  logic              epcs_sdo,
  output logic              epcs_data0,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(PROG_BUSY_CYC + 1);

  logic dclk_rise, dclk_fall, sce_s, sce_rise, sce_fall, sdo_s;

  epcs_resp_sync u_sync (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .dclk_i    (epcs_dclk),
    .sce_i     (epcs_sce),
    .sdo_i     (epcs_sdo),
    .dclk_rise (dclk_rise),
    .dclk_fall (dclk_fall),
    .sce_lvl   (sce_s),
    .sce_rise  (sce_rise),
    .sce_fall  (sce_fall),
    .sdo_lvl   (sdo_s)
  );

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [6:0]        shin_q, shin_d;
  logic [7:0]        shout_q, shout_d;
  logic [7:0]        op_q, op_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              data0_q, data0_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_we_q, mem_we_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              rd_valid_q, rd_valid_d;
  logic [7:0]        rd_buf_q, rd_buf_d;
  logic              wel_q, wel_d;
  logic [CNT_W-1:0]  busy_cnt_q, busy_cnt_d;
  logic              wrote_q, wrote_d;
  logic              pend_wren_q, pend_wren_d;
  logic              pend_wrdi_q, pend_wrdi_d;

  logic              wip, sweep_active;
  logic [7:0]        in_byte, rd_byte, status_byte, load_byte;

`ifdef EPCS_RESP_ERASE_EN
  localparam int SECT_BITS = (MEM_AW > SECTOR_BITS) ? SECTOR_BITS : MEM_AW;
  localparam logic [MEM_AW-1:0] SECT_MASK = MEM_AW'((64'd1 << SECT_BITS) - 64'd1);

  logic              sweep_q, sweep_d;
  logic              pend_erase_q, pend_erase_d;
  logic              erase_all_q, erase_all_d;
  logic [MEM_AW-1:0] sweep_end_q, sweep_end_d;
  logic [MEM_AW-1:0] erase_mask;

  assign sweep_active = sweep_q;
  assign erase_mask   = erase_all_q ? '1 : SECT_MASK;
`else
  assign sweep_active = 1'b0;
`endif

  assign wip     = (busy_cnt_q != '0) | sweep_active;
  assign in_byte = {shin_q, sdo_s};
  // mem_rdata is only valid for one cycle, so bypass the buffer on that cycle
  assign rd_byte = rd_valid_q ? mem_rdata : rd_buf_q;

  always_comb begin
    status_byte           = 8'h00;
    status_byte[STAT_WIP] = wip;
    status_byte[STAT_WEL] = wel_q;
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shin_d      = shin_q;
    shout_d     = shout_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data0_d     = data0_q;
    mem_rd_d    = 1'b0;
    mem_we_d    = 1'b0;
    wdata_d     = wdata_q;
    rd_valid_d  = mem_rd_q;
    rd_buf_d    = rd_byte;
    wel_d       = wel_q;
    busy_cnt_d  = (busy_cnt_q != '0) ? busy_cnt_q - 1'b1 : busy_cnt_q;
    wrote_d     = wrote_q;
    pend_wren_d = pend_wren_q;
    pend_wrdi_d = pend_wrdi_q;
    load_byte   = 8'hFF;
`ifdef EPCS_RESP_ERASE_EN
    sweep_d      = sweep_q;
    pend_erase_d = pend_erase_q;
    erase_all_d  = erase_all_q;
    sweep_end_d  = sweep_end_q;
    if (sweep_q) begin
      if (addr_q == sweep_end_q) begin
        sweep_d = 1'b0;
      end else begin
        addr_d   = addr_q + 1'b1;
        mem_we_d = 1'b1;
      end
    end
`endif

    // page program: step the low byte only, after the write strobe has been seen
    if (mem_we_q && state_q == ST_DATA_WR) begin
      addr_d = {addr_q[MEM_AW-1:8], addr_q[7:0] + 8'd1};
    end

    if (sce_s) begin
      if (sce_rise) begin
        if (pend_wren_q) wel_d = 1'b1;
        if (pend_wrdi_q) wel_d = 1'b0;
        if (state_q == ST_DATA_WR && wrote_q) begin
          wel_d      = 1'b0;
          busy_cnt_d = CNT_W'(PROG_BUSY_CYC);
        end
`ifdef EPCS_RESP_ERASE_EN
        if (pend_erase_q) begin
          wel_d       = 1'b0;
          sweep_d     = 1'b1;
          mem_we_d    = 1'b1;
          wdata_d     = 8'hFF;
          addr_d      = addr_q & ~erase_mask;
          sweep_end_d = (addr_q & ~erase_mask) | erase_mask;
        end
`endif
      end
      state_d     = ST_IDLE;
      bit_cnt_d   = 3'd0;
      byte_cnt_d  = 2'd0;
      data0_d     = 1'b1;
      wrote_d     = 1'b0;
      pend_wren_d = 1'b0;
      pend_wrdi_d = 1'b0;
`ifdef EPCS_RESP_ERASE_EN
      pend_erase_d = 1'b0;
`endif
    end else if (state_q == ST_IDLE) begin
      if (sce_fall) begin
        state_d   = ST_CMD;
        bit_cnt_d = 3'd0;
      end
    end else if (dclk_rise) begin
      shin_d    = in_byte[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        case (state_q)
          ST_CMD: begin
            op_d       = in_byte;
            byte_cnt_d = 2'd0;
            state_d    = ST_IGNORE;
            if (!wip || in_byte == OP_RDSR) begin
              case (in_byte)
                OP_READ: state_d = ST_ADDR;
                OP_RDSR: state_d = ST_STATUS;
                OP_WREN: pend_wren_d = 1'b1;
                OP_WRDI: pend_wrdi_d = 1'b1;
                OP_PP:   if (wel_q) state_d = ST_ADDR;
                OP_RDID: state_d = ST_DUMMY;
`ifdef EPCS_RESP_ERASE_EN
                OP_SE:   if (wel_q) state_d = ST_ADDR;
                OP_BE:   if (wel_q) begin
                  pend_erase_d = 1'b1;
                  erase_all_d  = 1'b1;
                end
`endif
                default: state_d = ST_IGNORE;
              endcase
            end
          end
          ST_ADDR: begin
            addr_d     = MEM_AW'({addr_q, in_byte});
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd2) begin
              state_d = ST_IGNORE;
              if (op_q == OP_READ) begin
                state_d  = ST_DATA_RD;
                mem_rd_d = 1'b1;
              end else if (op_q == OP_PP) begin
                state_d = ST_DATA_WR;
              end
`ifdef EPCS_RESP_ERASE_EN
              else if (op_q == OP_SE) begin
                pend_erase_d = 1'b1;
                erase_all_d  = 1'b0;
              end
`endif
            end
          end
          ST_DUMMY: begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd2) state_d = ST_ID;
          end
          ST_DATA_WR: begin
            mem_we_d = 1'b1;
            wdata_d  = in_byte;
            wrote_d  = 1'b1;
          end
          default: ;
        endcase
      end
    end else if (dclk_fall) begin
      if (state_q == ST_STATUS || state_q == ST_DATA_RD || state_q == ST_ID) begin
        if (bit_cnt_q == 3'd0) begin
          case (state_q)
            ST_STATUS: load_byte = status_byte;
            ST_ID:     load_byte = SILICON_ID;
            default: begin
              load_byte = rd_byte;
              addr_d    = addr_q + 1'b1;
              mem_rd_d  = 1'b1;
            end
          endcase
          data0_d = load_byte[7];
          shout_d = {load_byte[6:0], 1'b1};
        end else begin
          data0_d = shout_q[7];
          shout_d = {shout_q[6:0], 1'b1};
        end
      end else begin
        data0_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= 2'd0;
      shin_q      <= 7'd0;
      shout_q     <= 8'hFF;
      op_q        <= 8'h00;
      addr_q      <= '0;
      data0_q     <= 1'b1;
      mem_rd_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      wdata_q     <= 8'h00;
      rd_valid_q  <= 1'b0;
      rd_buf_q    <= 8'h00;
      wel_q       <= 1'b0;
      busy_cnt_q  <= '0;
      wrote_q     <= 1'b0;
      pend_wren_q <= 1'b0;
      pend_wrdi_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shin_q      <= shin_d;
      shout_q     <= shout_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data0_q     <= data0_d;
      mem_rd_q    <= mem_rd_d;
      mem_we_q    <= mem_we_d;
      wdata_q     <= wdata_d;
      rd_valid_q  <= rd_valid_d;
      rd_buf_q    <= rd_buf_d;
      wel_q       <= wel_d;
      busy_cnt_q  <= busy_cnt_d;
      wrote_q     <= wrote_d;
      pend_wren_q <= pend_wren_d;
      pend_wrdi_q <= pend_wrdi_d;
    end
  end

`ifdef EPCS_RESP_ERASE_EN
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sweep_q      <= 1'b0;
      pend_erase_q <= 1'b0;
      erase_all_q  <= 1'b0;
      sweep_end_q  <= '0;
    end else begin
      sweep_q      <= sweep_d;
      pend_erase_q <= pend_erase_d;
      erase_all_q  <= erase_all_d;
      sweep_end_q  <= sweep_end_d;
    end
  end
`endif

  assign epcs_data0 = data0_q;
  assign mem_addr   = addr_q;
  assign mem_rd     = mem_rd_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = wdata_q;
  assign busy       = wip;

endmodule

// File: tb/tb_epcs_flash_responder.sv
// tb/tb_epcs_flash_responder.sv - directed and randomized bench for epcs_flash_responder
module tb_epcs_flash_responder;

  localparam int AW    = 10;
  localparam int MSIZE = 1 << AW;
  localparam int PBUSY = 600;
  localparam int HALF  = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dclk = 1'b0, sce = 1'b1, sdo = 1'b0;
  logic          data0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd, mem_we, busy;
  logic [7:0]    mem_rdata = 8'h00;
  logic [7:0]    mem_wdata;

  epcs_flash_responder #(.MEM_AW(AW), .SILICON_ID(8'h14), .PROG_BUSY_CYC(PBUSY)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .epcs_dclk(dclk), .epcs_sce(sce), .epcs_sdo(sdo),
    .epcs_data0(data0), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [MSIZE];
  logic [7:0]  ref_mem [MSIZE];
  logic [17:0] wlog[$];
  logic [17:0] exp_log[$];
  logic [7:0]  tx_q[$], rx_q[$], dq[$];
  int          rd_cnt = 0, overlap = 0, busy_cycles = 0, we_nobusy = 0;
  int          passed = 0, total = 0;
  logic        model_wel = 1'b0;

  always @(posedge clk) begin
    if (mem_rd) begin
      mem_rdata <= mem[mem_addr];
      rd_cnt++;
    end
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wlog.push_back({mem_addr, mem_wdata});
      if (!busy) we_nobusy++;
    end
    if (mem_rd && mem_we) overlap++;
    if (busy) busy_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic txn(input int nbits);
    logic [7:0] b, r;
    r = 8'h00;
    rx_q.delete();
    @(negedge clk);
    sce = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      b   = tx_q[i / 8];
      sdo = b[7 - (i % 8)];
      repeat (HALF) @(negedge clk);
      r    = {r[6:0], data0};
      dclk = 1'b1;
      if (i % 8 == 7) rx_q.push_back(r);
      repeat (HALF) @(negedge clk);
      dclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    sce = 1'b1;
    sdo = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cmd1(input logic [7:0] op);
    tx_q = {op};
    txn(8);
    if (op == 8'h06) model_wel = 1'b1;
    if (op == 8'h04) model_wel = 1'b0;
  endtask

  task automatic rdsr(input int n);
    tx_q = {8'h05};
    for (int k = 0; k < n; k++) tx_q.push_back(8'h00);
    txn(8 * (n + 1));
  endtask

  // page program of dq at flash address a; model applies page wrap and WEL gating
  task automatic pp(input logic [23:0] a);
    int base, page_off;
    tx_q = {8'h02, a[23:16], a[15:8], a[7:0]};
    foreach (dq[k]) tx_q.push_back(dq[k]);
    wlog.delete();
    exp_log.delete();
    busy_cycles = 0;
    txn(8 * (4 + dq.size()));
    if (model_wel) begin
      base     = int'(a) % MSIZE;
      page_off = base % 256;
      foreach (dq[k]) begin
        int pa;
        pa = base - page_off + (page_off + k) % 256;
        ref_mem[pa] = dq[k];
        exp_log.push_back({pa[AW-1:0], dq[k]});
      end
      if (dq.size() > 0) model_wel = 1'b0;
    end
  endtask

  task automatic check_log(input string tag);
    check({tag, "_wcount"}, wlog.size(), exp_log.size());
    foreach (exp_log[k])
      if (k < wlog.size()) check({tag, "_write"}, {14'd0, wlog[k]}, {14'd0, exp_log[k]});
  endtask

  task automatic rd_check(input string tag, input logic [23:0] a, input int n);
    tx_q = {8'h03, a[23:16], a[15:8], a[7:0]};
    for (int k = 0; k < n; k++) tx_q.push_back(8'h00);
    txn(8 * (4 + n));
    for (int k = 0; k < n; k++)
      check(tag, rx_q[4 + k], ref_mem[(int'(a) + k) % MSIZE]);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("busy_timeout", n < 5000, 1);
  endtask

  initial begin
    logic [7:0]  v;
    logic [23:0] a;
    int          n, polls, bad;
    for (int i = 0; i < MSIZE; i++) begin
      v = 8'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    repeat (3) @(negedge clk);
    check("rst_data0", data0, 1);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // WREN + page program, status while busy, exact busy duration, read back
    cmd1(8'h06);
    dq = {8'hA5, 8'h5A};
    pp(24'h000010);
    check_log("pp_basic");
    check("busy_after_pp", busy, 1);
    rdsr(2);
    check("status_busy0", rx_q[1], {6'd0, model_wel, 1'b1});
    check("status_busy1", rx_q[2], {6'd0, model_wel, 1'b1});
    polls = 0;
    do begin
      rdsr(1);
      polls++;
    end while (rx_q[1] != 8'h00 && polls < 10);
    check("status_done", rx_q[1], 8'h00);
    check("busy_cycles", busy_cycles, PBUSY);
    rd_check("read_basic", 24'h000010, 2);

    // page program without WREN must not write
    dq = {8'h77};
    pp(24'h000020);
    check_log("pp_nowel");
    check("busy_nowel", busy, 0);
    rd_check("read_nowel", 24'h000020, 1);

    // page wrap within the 256-byte page
    cmd1(8'h06);
    dq.delete();
    for (int k = 0; k < 4; k++) dq.push_back(8'($urandom));
    pp(24'h0000FE);
    check_log("pp_wrap");
    wait_ready();
    rd_check("read_wrap_hi", 24'h0000FE, 2);
    rd_check("read_wrap_lo", 24'h000000, 2);

    // READ ID and aborted READ
    tx_q = {8'hAB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    txn(48);
    check("rdid0", rx_q[4], 8'h14);
    check("rdid1", rx_q[5], 8'h14);
    rd_cnt = 0;
    tx_q = {8'h03};
    txn(5);
    check("abort_no_rd", rd_cnt, 0);
    check("abort_data0", data0, 1);
    rdsr(1);
    check("abort_status", rx_q[1], {6'd0, model_wel, 1'b0});

    // bulk erase
    cmd1(8'h06);
    wlog.delete();
    we_nobusy = 0;
    tx_q = {8'hC7};
    txn(8);
`ifdef EPCS_RESP_ERASE_EN
    wait_ready();
    model_wel = 1'b0;
    for (int i = 0; i < MSIZE; i++) ref_mem[i] = 8'hFF;
    check("erase_wcount", wlog.size(), MSIZE);
    bad = 0;
    foreach (wlog[k]) if (wlog[k][7:0] != 8'hFF || int'(wlog[k][17:8]) != k) bad++;
    check("erase_pattern", bad, 0);
    check("erase_we_busy", we_nobusy, 0);
    rdsr(1);
    check("erase_status", rx_q[1], 8'h00);
    rd_check("erase_read", 24'h000123, 2);
`else
    repeat (20) @(negedge clk);
    check("be_ignored_wcount", wlog.size(), 0);
    rdsr(1);
    check("be_ignored_status", rx_q[1], {6'd0, model_wel, 1'b0});
    cmd1(8'h04);
    rdsr(1);
    check("wrdi_status", rx_q[1], {6'd0, model_wel, 1'b0});
`endif

    // randomized program/read-back against the flash model
    for (int it = 0; it < 6; it++) begin
      a = 24'($urandom);
      n = $urandom_range(1, 5);
      dq.delete();
      for (int k = 0; k < n; k++) dq.push_back(8'($urandom));
      if (it != 3) cmd1(8'h06);
      pp(a);
      check_log("rnd_pp");
      wait_ready();
      rd_check("rnd_read", a, n);
    end
    rd_check("rnd_wrap_read", 24'h0003FE, 3);

    check("rd_we_overlap", overlap, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
